// File: rtl/secded_pipe.sv
// secded_pipe: two-stage pipelined SECDED (extended Hamming) encoder/decoder.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_mode 0 = encode, 1 = decode
//   in_data, in_chk        data word and received check field (decode only)
//   out_valid/out_ready    output handshake
//   out_data, out_chk      encode: data + computed check; decode: corrected word
//   out_sbe, out_dbe       decode: single-bit corrected / uncorrectable error
//   clr_cnt                synchronous clear of both error counters
//   cnt_sbe, cnt_dbe       saturating counts of flagged output transfers
//
// Code layout: positions 1..DATA_W+CHK_W-1, check bit i at position 2^i,
// data bits fill the remaining positions in ascending order. The top check
// bit is the even overall parity of the data and the positional check bits.
module secded_pipe #(
    parameter int DATA_W = 16,
    parameter int CHK_W  = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_chk,
    output logic              out_sbe,
    output logic              out_dbe,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_sbe,
    output logic [CNT_W-1:0]  cnt_dbe
);

    localparam int TOP = DATA_W + CHK_W - 1;   // highest code position
    localparam int PW  = CHK_W - 1;            // number of positional check bits
    localparam logic [PW-1:0] TOP_SYN = PW'(TOP);

    generate
        if (DATA_W < 4 || DATA_W > 64 || CHK_W < 3 ||
            (1 << (CHK_W - 1)) < DATA_W + CHK_W ||
            (1 << (CHK_W - 2)) >= DATA_W + CHK_W - 1) begin : g_param_err
            $error("secded_pipe: DATA_W/CHK_W combination is not legal");
        end
    endgenerate

    // Code position of data bit k (k-th position that is not a power of two).
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= TOP; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Positions covered by positional check bit i.
    function automatic logic [TOP:1] cover_mask(input int i);
        logic [TOP:1] m;
        m = '0;
        for (int p = 1; p <= TOP; p++) m[p] = ((p >> i) & 1) != 0;
        return m;
    endfunction

    genvar gi;

    // ---------------- Stage 1 input-side logic ----------------
    logic [TOP:1]  in_cw;        // data scattered into code positions, checks zero
    logic [PW-1:0] enc_pos;      // recomputed positional check bits
    logic          enc_par;
    logic [PW-1:0] in_syn;
    logic          in_par_err;

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_scatter
            assign in_cw[data_pos(gi)] = in_data[gi];
        end
        for (gi = 0; gi < PW; gi++) begin : g_chkpos
            assign in_cw[1 << gi] = 1'b0;
            assign enc_pos[gi]    = ^(in_cw & cover_mask(gi));
        end
    endgenerate

    assign enc_par    = (^in_data) ^ (^enc_pos);
    assign in_syn     = enc_pos ^ in_chk[PW-1:0];
    // Parity over every received bit, overall check bit included.
    assign in_par_err = (^in_data) ^ (^in_chk);

    // ---------------- Handshake ----------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_take;

    assign s2_take  = ~s2_valid_reg | out_ready;
    assign in_ready = ~s1_valid_reg | s2_take;

    // ---------------- Stage 1 registers ----------------
    logic              s1_mode_reg;
    logic [DATA_W-1:0] s1_data_reg;
    logic [CHK_W-1:0]  s1_chk_reg;
    logic [PW-1:0]     s1_syn_reg;
    logic              s1_perr_reg;

    // Encode words carry a zero syndrome/parity so stage 2 passes them through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_data_reg  <= '0;
            s1_chk_reg   <= '0;
            s1_syn_reg   <= '0;
            s1_perr_reg  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_mode_reg <= in_mode;
                s1_data_reg <= in_data;
                s1_chk_reg  <= in_mode ? in_chk : {enc_par, enc_pos};
                s1_syn_reg  <= in_mode ? in_syn : '0;
                s1_perr_reg <= in_mode & in_par_err;
            end
        end
    end

    // ---------------- Stage 2 correction ----------------
    logic [TOP:1]      flip;
    logic              corr_pos;
    logic              corr_par;
    logic              sbe_next;
    logic              dbe_next;
    logic [DATA_W-1:0] cor_data;
    logic [CHK_W-1:0]  cor_chk;

    assign corr_pos = s1_mode_reg & s1_perr_reg & (s1_syn_reg != '0) & (s1_syn_reg <= TOP_SYN);
    assign corr_par = s1_mode_reg & s1_perr_reg & (s1_syn_reg == '0);
    assign sbe_next = s1_mode_reg & s1_perr_reg & (s1_syn_reg <= TOP_SYN);
    // Odd parity with an impossible syndrome, or even parity with a nonzero one.
    assign dbe_next = s1_mode_reg & ((s1_perr_reg & (s1_syn_reg > TOP_SYN)) |
                                     (~s1_perr_reg & (s1_syn_reg != '0)));

    always_comb begin
        flip = '0;
        for (int p = 1; p <= TOP; p++) begin
            flip[p] = corr_pos & (s1_syn_reg == PW'(p));
        end
    end

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_cor_data
            assign cor_data[gi] = s1_data_reg[gi] ^ flip[data_pos(gi)];
        end
        for (gi = 0; gi < PW; gi++) begin : g_cor_chk
            assign cor_chk[gi] = s1_chk_reg[gi] ^ flip[1 << gi];
        end
    endgenerate
    assign cor_chk[PW] = s1_chk_reg[PW] ^ corr_par;

    // ---------------- Stage 2 registers ----------------
    logic [DATA_W-1:0] s2_data_reg;
    logic [CHK_W-1:0]  s2_chk_reg;
    logic              s2_sbe_reg;
    logic              s2_dbe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_chk_reg   <= '0;
            s2_sbe_reg   <= 1'b0;
            s2_dbe_reg   <= 1'b0;
        end else if (s2_take) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= cor_data;
                s2_chk_reg  <= cor_chk;
                s2_sbe_reg  <= sbe_next;
                s2_dbe_reg  <= dbe_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_chk   = s2_chk_reg;
    assign out_sbe   = s2_sbe_reg;
    assign out_dbe   = s2_dbe_reg;

    // ---------------- Error counters ----------------
    logic             out_fire;
    logic [CNT_W-1:0] cnt_sbe_reg;
    logic [CNT_W-1:0] cnt_dbe_reg;

    assign out_fire = s2_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sbe_reg <= '0;
            cnt_dbe_reg <= '0;
        end else if (clr_cnt) begin
            cnt_sbe_reg <= '0;
            cnt_dbe_reg <= '0;
        end else begin
            if (out_fire && s2_sbe_reg && cnt_sbe_reg != '1)
                cnt_sbe_reg <= cnt_sbe_reg + CNT_W'(1);
            if (out_fire && s2_dbe_reg && cnt_dbe_reg != '1)
                cnt_dbe_reg <= cnt_dbe_reg + CNT_W'(1);
        end
    end

    assign cnt_sbe = cnt_sbe_reg;
    assign cnt_dbe = cnt_dbe_reg;

endmodule

// File: tb/tb_secded_pipe.sv
// Testbench for secded_pipe (DATA_W=16, CHK_W=6, CNT_W=2).
// Expected results are pushed to a scoreboard queue when a word is accepted
// and compared against the DUT output on every negative clock edge.
module tb_secded_pipe;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  chk;
        logic        sbe;
        logic        dbe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = '0;
    logic [5:0]  in_chk = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [5:0]  out_chk;
    logic        out_sbe;
    logic        out_dbe;
    logic        clr_cnt = 1'b0;
    logic [1:0]  cnt_sbe;
    logic [1:0]  cnt_dbe;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [1:0] exp_cs = '0;
    logic [1:0] exp_cd = '0;
    bit   rand_done;

    secded_pipe #(.DATA_W(16), .CHK_W(6), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_chk(in_chk),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chk(out_chk),
        .out_sbe(out_sbe), .out_dbe(out_dbe),
        .clr_cnt(clr_cnt), .cnt_sbe(cnt_sbe), .cnt_dbe(cnt_dbe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic [5:0] c, input logic s, input logic b);
        exp_t r;
        r.data = d; r.chk = c; r.sbe = s; r.dbe = b;
        return r;
    endfunction

    // Reference model: extended Hamming code over positions 1..21.
    function automatic exp_t model(input logic m, input logic [15:0] d, input logic [5:0] c);
        logic [21:1] cw;
        logic [4:0]  s;
        logic        p;
        exp_t        r;
        int          k;
        int          ci;
        k = 0; ci = 0; cw = '0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                cw[pos] = m ? c[ci] : 1'b0;
                ci++;
            end else begin
                cw[pos] = d[k];
                k++;
            end
        end
        s = '0;
        for (int i = 0; i < 5; i++)
            for (int pos = 1; pos <= 21; pos++)
                if (((pos >> i) & 1) == 1) s[i] = s[i] ^ cw[pos];
        r = mk(d, c, 1'b0, 1'b0);
        if (!m) begin
            r.chk = {(^d) ^ (^s), s};
            return r;
        end
        p = (^cw) ^ c[5];
        if (p && s == 5'd0) begin
            r.chk[5] = ~c[5];
            r.sbe = 1'b1;
        end else if (p && s <= 5'd21) begin
            cw[s] = ~cw[s];
            r.sbe = 1'b1;
            k = 0; ci = 0;
            for (int pos = 1; pos <= 21; pos++) begin
                if ((pos & (pos - 1)) == 0) begin
                    r.chk[ci] = cw[pos];
                    ci++;
                end else begin
                    r.data[k] = cw[pos];
                    k++;
                end
            end
        end else if (s != 5'd0) begin
            r.dbe = 1'b1;
        end
        return r;
    endfunction

    task automatic send(input logic m, input logic [15:0] d, input logic [5:0] c, input exp_t e);
        int waited;
        waited = 0;
        in_valid = 1'b1; in_mode = m; in_data = d; in_chk = c;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("send_timeout_in_ready", in_ready, 1);
        else sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_queue_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Builds a random codeword and flips nflip distinct bits of {chk, data}.
    task automatic rand_word(input int nflip, output logic [15:0] d, output logic [5:0] c);
        exp_t e;
        logic [21:0] v;
        int i1, i2, i3;
        d = 16'($urandom);
        e = model(1'b0, d, 6'd0);
        v = {e.chk, d};
        i1 = $urandom_range(0, 21);
        i2 = (i1 + $urandom_range(1, 10)) % 22;
        i3 = (i1 + $urandom_range(11, 21)) % 22;
        if (nflip >= 1) v[i1] = ~v[i1];
        if (nflip >= 2) v[i2] = ~v[i2];
        if (nflip >= 3) v[i3] = ~v[i3];
        d = v[15:0];
        c = v[21:16];
    endtask

    // Output monitor / scoreboard and counter model.
    initial begin
        exp_t h;
        logic fire;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_cs = '0;
                exp_cd = '0;
            end else begin
                check_eq("cnt_sbe", cnt_sbe, exp_cs);
                check_eq("cnt_dbe", cnt_dbe, exp_cd);
                fire = 1'b0;
                h = mk('0, '0, 1'b0, 1'b0);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out_valid", out_valid, 0);
                    end else begin
                        h = sb[0];
                        check_eq("out_data", out_data, h.data);
                        check_eq("out_chk", out_chk, h.chk);
                        check_eq("out_sbe", out_sbe, h.sbe);
                        check_eq("out_dbe", out_dbe, h.dbe);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            fire = 1'b1;
                        end
                    end
                end
                if (clr_cnt) begin
                    exp_cs = '0;
                    exp_cd = '0;
                end else if (fire) begin
                    if (h.sbe && exp_cs != 2'd3) exp_cs = exp_cs + 2'd1;
                    if (h.dbe && exp_cd != 2'd3) exp_cd = exp_cd + 2'd1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [5:0]  c;
        logic        m;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_chk", out_chk, 0);
        check_eq("rst_out_sbe", out_sbe, 0);
        check_eq("rst_out_dbe", out_dbe, 0);
        check_eq("rst_cnt_sbe", cnt_sbe, 0);
        check_eq("rst_cnt_dbe", cnt_dbe, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Known vectors, with latency check on the first
        send(1'b0, 16'h0001, 6'h00, mk(16'h0001, 6'h23, 1'b0, 1'b0));
        @(negedge clk);
        check_eq("latency_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        check_eq("latency_cycle2_out_valid", out_valid, 1);
        @(posedge clk); #1;
        send(1'b0, 16'h0000, 6'h15, mk(16'h0000, 6'h00, 1'b0, 1'b0));
        send(1'b1, 16'h0001, 6'h23, mk(16'h0001, 6'h23, 1'b0, 1'b0));
        send(1'b1, 16'h0003, 6'h23, mk(16'h0001, 6'h23, 1'b1, 1'b0));
        send(1'b1, 16'h0007, 6'h23, mk(16'h0007, 6'h23, 1'b0, 1'b1));
        drain();
        check_eq("vec_cnt_sbe", cnt_sbe, 1);
        check_eq("vec_cnt_dbe", cnt_dbe, 1);

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    m = ($urandom_range(0, 3) != 0);
                    rand_word(m ? $urandom_range(0, 3) : 0, d, c);
                    send(m, d, c, model(m, d, c));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Stall: two words accepted, third blocked while out_ready is low
        out_ready = 1'b0;
        rand_word(1, d, c); send(1'b1, d, c, model(1'b1, d, c));
        rand_word(0, d, c); send(1'b1, d, c, model(1'b1, d, c));
        rand_word(2, d, c);
        in_valid = 1'b1; in_mode = 1'b1; in_data = d; in_chk = c;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("unstall_in_ready", in_ready, 1);
        sb.push_back(model(1'b1, d, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Counter saturation and clear-wins
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check_eq("clr_cnt_sbe", cnt_sbe, 0);
        for (int n = 0; n < 5; n++) begin
            rand_word(0, d, c);
            d[n] = ~d[n];
            send(1'b1, d, c, model(1'b1, d, c));
        end
        drain();
        check_eq("sat_cnt_sbe", cnt_sbe, 3);
        rand_word(0, d, c);
        d[7] = ~d[7];
        send(1'b1, d, c, model(1'b1, d, c));
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check_eq("clr_wins_cnt_sbe", cnt_sbe, 0);
        check_eq("clr_queue_empty", sb.size(), 0);

        // Reset with words in flight
        send(1'b1, 16'h0007, 6'h23, mk(16'h0007, 6'h23, 1'b0, 1'b1));
        drain();
        check_eq("pre_rst_cnt_dbe", cnt_dbe, 1);
        out_ready = 1'b0;
        rand_word(1, d, c); send(1'b1, d, c, model(1'b1, d, c));
        rand_word(0, d, c); send(1'b1, d, c, model(1'b1, d, c));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_cnt_dbe", cnt_dbe, 0);
        check_eq("midrst_cnt_sbe", cnt_sbe, 0);
        check_eq("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("postrst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(1'b1, 16'h0003, 6'h23, mk(16'h0001, 6'h23, 1'b1, 1'b0));
        drain();
        check_eq("final_cnt_sbe", cnt_sbe, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
